// File: rtl/ram_view_pkg.sv
// rtl/ram_view_pkg.sv - colour constants, cell classes and scroll states shared by the RAM dump viewer
package ram_view_pkg;

  localparam logic [2:0] C_ONE     = 3'b110;
  localparam logic [2:0] C_ZERO    = 3'b001;
  localparam logic [2:0] C_HL_ONE  = 3'b111;
  localparam logic [2:0] C_HL_ZERO = 3'b100;
  localparam logic [2:0] C_BLACK   = 3'b000;

  typedef enum logic [1:0] {BLACK, LABEL, HEADER, DATA} cell_class_e;

  typedef enum logic [1:0] {P_NONE, P_DOWN, P_UP} pend_e;

  function automatic logic [2:0] bit_colour(input logic b, input logic hl);
    if (hl) return b ? C_HL_ONE : C_HL_ZERO;
    return b ? C_ONE : C_ZERO;
  endfunction

endpackage

// File: rtl/ram_view_scroll.sv
// rtl/ram_view_scroll.sv - page scroll request FSM and base_row register, applied only at frame start
module ram_view_scroll
  import ram_view_pkg::*;
#(
  parameter int DEPTH_ROWS = 64,
  parameter int VIS_ROWS   = 63,
  parameter int ROW_W      = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_start,
  input  logic             page_up,
  input  logic             page_down,
  output logic [ROW_W-1:0] base_row
);

  localparam int              STEP    = VIS_ROWS % DEPTH_ROWS;
  localparam logic [ROW_W:0]  STEP_V  = (ROW_W+1)'(STEP);
  localparam logic [ROW_W:0]  DEPTH_V = (ROW_W+1)'(DEPTH_ROWS);

  pend_e            pending;
  logic [ROW_W:0]   fwd_sum;
  logic [ROW_W-1:0] base_fwd;
  logic [ROW_W-1:0] base_back;

  always_comb begin
    fwd_sum  = {1'b0, base_row} + STEP_V;
    base_fwd = (fwd_sum >= DEPTH_V) ? ROW_W'(fwd_sum - DEPTH_V) : fwd_sum[ROW_W-1:0];
    if ({1'b0, base_row} >= STEP_V)
      base_back = ROW_W'({1'b0, base_row} - STEP_V);
    else
      base_back = ROW_W'({1'b0, base_row} + DEPTH_V - STEP_V);
  end

  // Opposite requests cancel each other, whether simultaneous or against a pending one.
  function automatic pend_e next_pend(input pend_e cur, input logic up, input logic down);
    if (up && down) return P_NONE;
    if (down)       return (cur == P_UP) ? P_NONE : P_DOWN;
    if (up)         return (cur == P_DOWN) ? P_NONE : P_UP;
    return cur;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending  <= P_NONE;
      base_row <= '0;
    end else if (frame_start) begin
      case (pending)
        P_DOWN:  base_row <= base_fwd;
        P_UP:    base_row <= base_back;
        default: base_row <= base_row;
      endcase
      pending <= next_pend(P_NONE, page_up, page_down);
    end else begin
      pending <= next_pend(pending, page_up, page_down);
    end
  end

endmodule

// File: rtl/ram_dump_view.sv
// rtl/ram_dump_view.sv - renders the debug RAM as a grid of bit cells with row labels, column header,
// page scrolling and one highlighted word; 3-cycle pipeline from prefetch counters to VGA pins
module ram_dump_view
  import ram_view_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int COLS       = 16,
  parameter int DEPTH_ROWS = 64,
  parameter int VIS_ROWS   = 63,
  parameter int CELL_LOG2  = 3,
  parameter int ADDR_W     = $clog2(DEPTH_ROWS*COLS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [10:0]       counter_x,
  input  logic [10:0]       counter_y,
  input  logic              in_display_area,
  input  logic              page_up,
  input  logic              page_down,
  input  logic              hl_en,
  input  logic [ADDR_W-1:0] hl_addr,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_data,
  output logic              vga_r,
  output logic              vga_g,
  output logic              vga_b
);

  localparam int             F       = DATA_W + 1;
  localparam int             CIF_W   = $clog2(F);
  localparam int             BIT_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int             ROW_W   = (DEPTH_ROWS > 1) ? $clog2(DEPTH_ROWS) : 1;
  localparam int             X_LIMIT = (COLS + 1) * F;
  localparam logic [10:0]    CELL_MASK = 11'((1 << CELL_LOG2) - 1);
  localparam logic [ROW_W:0] DEPTH_V = (ROW_W+1)'(DEPTH_ROWS);

  logic [10:0]       cx, cy;
  logic              x_edge, y_edge, frame_start;
  logic [CIF_W-1:0]  cif_q, cif_c;
  logic [10:0]       fld_q, fld_c, vis_q, vis_c, col_c;
  logic [ROW_W-1:0]  base_row, abs_row;
  logic [ROW_W:0]    row_sum;
  logic [ADDR_W-1:0] addr_c;
  cell_class_e       cls_c;
  logic [DATA_W-1:0] val_c;
  logic [BIT_W-1:0]  bit_c;

  assign cx          = counter_x >> CELL_LOG2;
  assign cy          = counter_y >> CELL_LOG2;
  assign x_edge      = (counter_x & CELL_MASK) == 11'd0;
  assign y_edge      = (counter_y & CELL_MASK) == 11'd0;
  assign frame_start = (counter_x == 11'd0) && (counter_y == 11'd0);

  ram_view_scroll #(
    .DEPTH_ROWS (DEPTH_ROWS),
    .VIS_ROWS   (VIS_ROWS),
    .ROW_W      (ROW_W)
  ) u_scroll (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start),
    .page_up     (page_up),
    .page_down   (page_down),
    .base_row    (base_row)
  );

  // Counters hold the previous cell's position; the combinational next value is the current pixel's.
  always_comb begin
    cif_c = cif_q;
    fld_c = fld_q;
    if (counter_x == 11'd0) begin
      cif_c = '0;
      fld_c = '0;
    end else if (x_edge) begin
      if (cif_q == CIF_W'(F - 1)) begin
        cif_c = '0;
        fld_c = fld_q + 11'd1;
      end else begin
        cif_c = cif_q + 1'b1;
      end
    end
    vis_c = vis_q;
    if (counter_y == 11'd0)
      vis_c = '0;
    else if ((counter_x == 11'd0) && y_edge && cy[0] && (cy != 11'd1))
      vis_c = vis_q + 11'd1;
  end

  always_comb begin
    row_sum = {1'b0, base_row} + {1'b0, vis_c[ROW_W-1:0]};
    abs_row = (row_sum >= DEPTH_V) ? ROW_W'(row_sum - DEPTH_V) : row_sum[ROW_W-1:0];
    col_c   = (fld_c == 11'd0) ? 11'd0 : fld_c - 11'd1;
    addr_c  = ADDR_W'(32'(abs_row) * 32'(COLS) + 32'(col_c));
    val_c   = (fld_c == 11'd0) ? DATA_W'(abs_row) : DATA_W'(col_c);
    bit_c   = BIT_W'(DATA_W - 1) - BIT_W'(cif_c);
    cls_c   = BLACK;
    if (x_edge || y_edge || (32'(cx) >= X_LIMIT) || (cif_c == CIF_W'(DATA_W)))
      cls_c = BLACK;
    else if (cy == 11'd0)
      cls_c = (fld_c == 11'd0) ? BLACK : HEADER;
    else if (!cy[0] || (32'(vis_c) >= VIS_ROWS))
      cls_c = BLACK;
    else
      cls_c = (fld_c == 11'd0) ? LABEL : DATA;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cif_q <= '0;
      fld_q <= '0;
      vis_q <= '0;
    end else begin
      cif_q <= cif_c;
      fld_q <= fld_c;
      vis_q <= vis_c;
    end
  end

  cell_class_e       cls1, cls2;
  logic [DATA_W-1:0] val1, val2;
  logic [BIT_W-1:0]  bit1, bit2;
  logic              hl1, hl2, de1, de2;
  logic              bit_v;
  logic [2:0]        colour;

  // Stage 2 lines up with ram_data, which arrives one cycle after ram_addr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_addr <= '0;
      cls1     <= BLACK;
      val1     <= '0;
      bit1     <= '0;
      hl1      <= 1'b0;
      de1      <= 1'b0;
      cls2     <= BLACK;
      val2     <= '0;
      bit2     <= '0;
      hl2      <= 1'b0;
      de2      <= 1'b0;
      {vga_r, vga_g, vga_b} <= C_BLACK;
    end else begin
      ram_addr <= addr_c;
      cls1     <= cls_c;
      val1     <= val_c;
      bit1     <= bit_c;
      hl1      <= hl_en && (addr_c == hl_addr);
      de1      <= in_display_area;
      cls2     <= cls1;
      val2     <= val1;
      bit2     <= bit1;
      hl2      <= hl1;
      de2      <= de1;
      {vga_r, vga_g, vga_b} <= de2 ? colour : C_BLACK;
    end
  end

  always_comb begin
    bit_v  = (cls2 == DATA) ? ram_data[bit2] : val2[bit2];
    colour = C_BLACK;
    if (cls2 != BLACK)
      colour = bit_colour(bit_v, hl2 && (cls2 == DATA));
  end

endmodule

// File: tb/tb_ram_dump_view.sv
// tb/tb_ram_dump_view.sv - directed bench for ram_dump_view (default geometry plus a 4-bit/8-column/16px instance)
module tb_ram_dump_view;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] counter_x, counter_y;
  logic        in_display_area, page_up, page_down, hl_en;
  logic [9:0]  hl_addr;
  logic [9:0]  ram_addr;
  logic [7:0]  ram_data = '0;
  logic        vga_r, vga_g, vga_b;
  logic [8:0]  ram_addr2;
  logic [3:0]  ram_data2 = '0;
  logic        vga2_r, vga2_g, vga2_b;

  always #5 clk = ~clk;

  ram_dump_view dut (
    .clk(clk), .rst(rst), .counter_x(counter_x), .counter_y(counter_y),
    .in_display_area(in_display_area), .page_up(page_up), .page_down(page_down),
    .hl_en(hl_en), .hl_addr(hl_addr), .ram_addr(ram_addr), .ram_data(ram_data),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b)
  );

  ram_dump_view #(.DATA_W(4), .COLS(8), .CELL_LOG2(4)) dut2 (
    .clk(clk), .rst(rst), .counter_x(counter_x), .counter_y(counter_y),
    .in_display_area(in_display_area), .page_up(page_up), .page_down(page_down),
    .hl_en(hl_en), .hl_addr(hl_addr[8:0]), .ram_addr(ram_addr2), .ram_data(ram_data2),
    .vga_r(vga2_r), .vga_g(vga2_g), .vga_b(vga2_b)
  );

  // Synchronous-read RAMs: word k holds k's low bits, except word 0x11 of the main RAM holds 0xFF.
  always @(posedge clk) ram_data  <= (ram_addr == 10'h011) ? 8'hFF : ram_addr[7:0];
  always @(posedge clk) ram_data2 <= ram_addr2[3:0];

  int checks = 0;
  int failures = 0;
  int de_off_x = -1;
  int cap_vga[1300], cap_addr[1300], cap_vga2[1300], cap_addr2[1300];

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // cap_addr[x] holds ram_addr for pixel x; the colour for pixel x lands two entries later.
  task automatic run_line(input int y, input int n);
    for (int x = 0; x <= n + 2; x++) begin
      counter_x = 11'(x);
      counter_y = 11'(y);
      in_display_area = (x != de_off_x);
      @(posedge clk); #1;
      page_up = 1'b0;
      page_down = 1'b0;
      cap_addr[x]  = int'(ram_addr);
      cap_vga[x]   = int'({vga_r, vga_g, vga_b});
      cap_addr2[x] = int'(ram_addr2);
      cap_vga2[x]  = int'({vga2_r, vga2_g, vga2_b});
    end
  endtask

  task automatic run_frame(input int ylast, input int n);
    for (int y = 0; y < ylast; y++) run_line(y, 3);
    run_line(ylast, n);
  endtask

  task automatic pulse(input logic up, input logic down);
    counter_x = 11'd5;
    counter_y = 11'd100;
    page_up = up;
    page_down = down;
    @(posedge clk); #1;
    page_up = 1'b0;
    page_down = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    counter_x = '0; counter_y = '0; in_display_area = 1'b0;
    page_up = 1'b0; page_down = 1'b0; hl_en = 1'b0; hl_addr = 10'h011;
    repeat (3) @(posedge clk);
    #1;
    check("reset_vga", int'({vga_r, vga_g, vga_b}), 0);
    check("reset_addr", int'(ram_addr), 0);
    rst = 1'b0;

    // Frame 1: header, even row, data row 1
    run_line(0, 3);
    run_line(1, 270);
    check("hdr_label_black", cap_vga[25 + 2], 0);
    check("hdr_col0_bit7", cap_vga[73 + 2], 3'b001);
    check("hdr_col1_bit0", cap_vga[201 + 2], 3'b110);
    check("hdr_col2_bit1", cap_vga[265 + 2], 3'b110);
    for (int y = 2; y < 17; y++) run_line(y, 3);
    run_line(17, 80);
    check("even_row_black", cap_vga[73 + 2], 0);
    for (int y = 18; y < 25; y++) run_line(y, 3);
    de_off_x = 81;
    run_line(25, 1240);
    de_off_x = -1;
    check("r1c0_addr", cap_addr[73], 16);
    check("r1c0_bit7", cap_vga[73 + 2], 3'b001);
    check("grid_x72", cap_vga[72 + 2], 0);
    check("border_cx8", cap_vga[65 + 2], 0);
    check("label_bit0", cap_vga[57 + 2], 3'b110);
    check("word11_bit7", cap_vga[145 + 2], 3'b110);
    check("word12_bit6", cap_vga[225 + 2], 3'b001);
    check("word12_bit4", cap_vga[241 + 2], 3'b110);
    check("de_low_black", cap_vga[81 + 2], 0);
    check("col15_bit7", cap_vga[1153 + 2], 3'b001);
    check("col15_bit0", cap_vga[1209 + 2], 3'b110);
    check("past_last_field", cap_vga[1225 + 2], 0);

    // Highlight word 0x011
    hl_en = 1'b1;
    run_frame(25, 250);
    for (int b = 0; b < 8; b++) check("hl_bit", cap_vga[(18 + b) * 8 + 1 + 2], 3'b111);
    check("hl_left_nb", cap_vga[73 + 2], 3'b001);
    check("hl_right_nb", cap_vga[241 + 2], 3'b110);
    hl_en = 1'b0;

    // page_down mid-frame: takes effect only at the next frame start
    pulse(1'b0, 1'b1);
    run_line(25, 80);
    check("pd_pre_apply", cap_addr[73], 16);
    for (int y = 0; y < 9; y++) run_line(y, 3);
    run_line(9, 80);
    check("pd_row0_addr", cap_addr[73], 1008);
    for (int y = 10; y < 25; y++) run_line(y, 3);
    run_line(25, 80);
    check("pd_row1_addr", cap_addr[73], 0);
    check("pd_label_bit0", cap_vga[57 + 2], 3'b001);
    check("pd_word0_bit7", cap_vga[73 + 2], 3'b001);

    pulse(1'b1, 1'b1);
    run_frame(25, 80);
    check("both_cancel", cap_addr[73], 0);
    pulse(1'b1, 1'b0);
    run_frame(25, 80);
    check("pu_to_0", cap_addr[73], 16);
    pulse(1'b1, 1'b0);
    run_frame(25, 80);
    check("pu_wrap_1", cap_addr[73], 32);
    pulse(1'b0, 1'b1);
    pulse(1'b1, 1'b0);
    run_frame(25, 80);
    check("opposite_cancel", cap_addr[73], 32);

    // Request on the apply cycle waits one frame
    page_down = 1'b1;
    run_frame(25, 80);
    check("apply_cycle_defer", cap_addr[73], 32);
    run_frame(25, 80);
    check("apply_cycle_next", cap_addr[73], 16);
    pulse(1'b0, 1'b1);
    run_frame(25, 80);
    check("pd_again", cap_addr[73], 0);

    // Mid-frame reset
    for (int y = 0; y < 25; y++) run_line(y, 3);
    for (int x = 0; x <= 75; x++) begin
      counter_x = 11'(x); counter_y = 11'd25; in_display_area = 1'b1;
      @(posedge clk); #1;
    end
    check("pre_reset_lit", int'({vga_r, vga_g, vga_b}), 3'b001);
    rst = 1'b1;
    #1;
    check("reset_async_black", int'({vga_r, vga_g, vga_b}), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      counter_x = 11'(77 + i);
      @(posedge clk); #1;
      check("refill_black", int'({vga_r, vga_g, vga_b}), 0);
    end
    run_frame(25, 80);
    check("reset_base0", cap_addr[73], 16);

    // Small-geometry instance: 4-bit words, 8 columns, 16 px cells
    run_frame(81, 740);
    check("g4_addr_r2c3", cap_addr2[321], 19);
    check("g4_c3_bit3", cap_vga2[321 + 2], 3'b001);
    check("g4_c3_bit0", cap_vga2[369 + 2], 3'b110);
    check("g4_c7_bit3", cap_vga2[641 + 2], 3'b001);
    check("g4_c7_bit0", cap_vga2[689 + 2], 3'b110);
    check("g4_cx45_black", cap_vga2[721 + 2], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
